// File: rtl/axi_mem_slave.sv
// AXI-style 64-bit memory slave with byte strobes, range check and independent read/write FSMs.
// Latency: read data valid RD_LAT+1 cycles after AR handshake; write response one cycle after both beats held.
// Backpressure: R/B responses hold stable until accepted; AR stalls in R_WAIT/R_RESP, AW/W stall in W_RESP.
module axi_mem_slave #(
  parameter logic [63:0] BASE   = 64'h8000_0000,
  parameter int          DEPTH  = 256,
  parameter int          RD_LAT = 2
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [63:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [63:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Range test written as an offset compare so BASE + SPAN never has to be formed.
  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  // Word index drops the byte-lane bits of the offset from BASE.
  function automatic logic [IW-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return off[IW+2:3];
  endfunction

  logic [63:0] mem [DEPTH];

  // ---------------------------------------------------------------- read side
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [63:0] r_addr_q, r_addr_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_load;
  logic [63:0] r_look_addr;
  logic        ar_hs, r_hs;

  assign ar_hs = arvalid && arready_q;
  assign r_hs  = rvalid_q && rready;

  // With RD_LAT=0 the lookup happens on the AR edge itself, before araddr is latched.
  assign r_look_addr = (r_state_q == R_IDLE) ? araddr : r_addr_q;

  // Read FSM next state, latency countdown and response capture on entry to R_RESP.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr_d = araddr;
          r_cnt_d  = 4'(RD_LAT);
          if (RD_LAT == 0) begin
            r_state_d = R_RESP;
            r_load    = 1'b1;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q <= 4'd1) begin
          r_state_d = R_RESP;
          r_load    = 1'b1;
        end
      end
      R_RESP: begin
        if (r_hs) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    // Memory is read before any same-edge write lands, so a colliding read sees old data.
    if (r_load) begin
      if (in_range(r_look_addr)) begin
        rdata_d = mem[word_idx(r_look_addr)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // --------------------------------------------------------------- write side
  typedef enum logic {W_IDLE, W_RESP} w_state_e;

  w_state_e    w_state_q, w_state_d;
  logic        aw_have_q, aw_have_d;
  logic        w_have_q, w_have_d;
  logic [63:0] aw_addr_q, aw_addr_d;
  logic [63:0] w_data_q, w_data_d;
  logic [7:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, b_hs;
  logic        mem_we;
  logic [63:0] c_addr, c_data;
  logic [7:0]  c_strb;

  assign aw_hs = awvalid && awready_q;
  assign w_hs  = wvalid && wready_q;
  assign b_hs  = bvalid_q && bready;

  // Write FSM: collect AW and W in any order, commit on the edge both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    // Commit operands come from the holding regs or straight from the bus on the capture edge.
    c_addr    = aw_have_q ? aw_addr_q : awaddr;
    c_data    = w_have_q ? w_data_q : wdata;
    c_strb    = w_have_q ? w_strb_q : wstrb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          aw_addr_d = awaddr;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end
        if (aw_have_d && w_have_d) begin
          w_state_d = W_RESP;
          if (in_range(c_addr)) begin
            mem_we  = 1'b1;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_have_d;
    wready_d  = (w_state_d == W_IDLE) && !w_have_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM state, captured beats and registered write-channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-masked storage update; contents intentionally survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (c_strb[b]) mem[word_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule
